// File: rtl/pc_fetch_unit.sv
// Program-counter fetch sequencer: requests one instruction word, offers it to
// decode, waits for the retiring PC update, then fetches from the new PC.
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [63:0] NextPC,
    input  logic        PCUpdate,
    output logic        IMemReq,
    output logic [63:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instruction,
    output logic [63:0] CurrentPC,
    output logic [31:0] RetiredCount,
    output logic        MisalignFault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_count_q, retired_count_d;
    logic        fault_q, fault_d;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q         <= ST_IDLE;
            pc_q            <= RESET_PC;
            instr_q         <= 32'h0;
            retired_count_q <= 32'h0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            retired_count_q <= retired_count_d;
            fault_q         <= fault_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        retired_count_d = retired_count_q;
        fault_d         = fault_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (IMemAck) begin
                    instr_d = IMemData;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (InstrReady) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (PCUpdate) begin
                    pc_d            = NextPC;
                    retired_count_d = retired_count_q + 32'd1;
                    // A misaligned target is still loaded so software can see it.
                    if (NextPC[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decode the state register only; no input feeds them.
    assign IMemReq       = (state_q == ST_FETCH);
    assign InstrValid    = (state_q == ST_HOLD);
    assign IMemAddr      = pc_q;
    assign CurrentPC     = pc_q;
    assign Instruction   = instr_q;
    assign RetiredCount  = retired_count_q;
    assign MisalignFault = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit with a transaction-level reference model
// plus directed literal checks of reset, stall, wrap, fault and async reset.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [63:0] NextPC;
    logic        PCUpdate;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instruction;
    logic [63:0] CurrentPC;
    logic [31:0] RetiredCount;
    logic        MisalignFault;

    pc_fetch_unit dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .NextPC       (NextPC),
        .PCUpdate     (PCUpdate),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .IMemData     (IMemData),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Instruction  (Instruction),
        .CurrentPC    (CurrentPC),
        .RetiredCount (RetiredCount),
        .MisalignFault(MisalignFault)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_HOLD  = 2;
    localparam int P_EXEC  = 3;
    localparam int P_FAULT = 4;

    int          m_phase;
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;
    logic        m_fault;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_pc    = 64'h0;
        m_instr = 32'h0;
        m_cnt   = 32'h0;
        m_fault = 1'b0;
    endtask

    task automatic model_update(input logic ack, input logic [31:0] data,
                                input logic rdy, input logic upd, input logic [63:0] npc);
        case (m_phase)
            P_IDLE:  m_phase = P_FETCH;
            P_FETCH: if (ack) begin m_instr = data; m_phase = P_HOLD; end
            P_HOLD:  if (rdy) m_phase = P_EXEC;
            P_EXEC: begin
                if (upd) begin
                    m_pc  = npc;
                    m_cnt = m_cnt + 32'd1;
                    if (npc[1:0] != 2'b00) begin
                        m_fault = 1'b1;
                        m_phase = P_FAULT;
                    end else begin
                        m_phase = P_FETCH;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_model();
        cmp("IMemReq",       {63'h0, IMemReq},       {63'h0, m_phase == P_FETCH});
        cmp("InstrValid",    {63'h0, InstrValid},    {63'h0, m_phase == P_HOLD});
        cmp("IMemAddr",      IMemAddr,               m_pc);
        cmp("CurrentPC",     CurrentPC,              m_pc);
        cmp("Instruction",   {32'h0, Instruction},   {32'h0, m_instr});
        cmp("RetiredCount",  {32'h0, RetiredCount},  {32'h0, m_cnt});
        cmp("MisalignFault", {63'h0, MisalignFault}, {63'h0, m_fault});
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic step(input logic ack, input logic [31:0] data, input logic rdy,
                        input logic upd, input logic [63:0] npc);
        IMemAck    = ack;
        IMemData   = data;
        InstrReady = rdy;
        PCUpdate   = upd;
        NextPC     = npc;
        @(posedge CLK);
        model_update(ack, data, rdy, upd, npc);
        @(negedge CLK);
        check_model();
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2;
        Reset_L = 1'b0;
        #1;
        model_reset();
        cmp("async_rst_IMemReq",   {63'h0, IMemReq}, 64'h0);
        cmp("async_rst_CurrentPC", CurrentPC,        64'h0);
        check_model();
        @(posedge CLK);
        @(negedge CLK);
        check_model();
        Reset_L = 1'b1;
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] v;
        v = {$urandom, $urandom};
        if ($urandom_range(0, 15) != 0) v[1:0] = 2'b00;
        return v;
    endfunction

    initial begin
        Reset_L    = 1'b0;
        NextPC     = 64'h0;
        PCUpdate   = 1'b0;
        IMemAck    = 1'b0;
        IMemData   = 32'h0;
        InstrReady = 1'b0;
        model_reset();

        @(negedge CLK);
        @(negedge CLK);
        cmp("reset_IMemReq",       {63'h0, IMemReq},       64'h0);
        cmp("reset_InstrValid",    {63'h0, InstrValid},    64'h0);
        cmp("reset_CurrentPC",     CurrentPC,              64'h0);
        cmp("reset_Instruction",   {32'h0, Instruction},   64'h0);
        cmp("reset_RetiredCount",  {32'h0, RetiredCount},  64'h0);
        cmp("reset_MisalignFault", {63'h0, MisalignFault}, 64'h0);
        Reset_L = 1'b1;

        // First fetch: ack in second FETCH cycle.
        step(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        cmp("fetch1_IMemReq",  {63'h0, IMemReq}, 64'h1);
        cmp("fetch1_IMemAddr", IMemAddr,         64'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        cmp("fetch2_IMemReq",  {63'h0, IMemReq}, 64'h1);
        step(1'b1, 32'h8B02_0020, 1'b0, 1'b0, 64'h0);
        cmp("hold_InstrValid",  {63'h0, InstrValid},  64'h1);
        cmp("hold_Instruction", {32'h0, Instruction}, 64'h8B02_0020);
        cmp("hold_IMemReq",     {63'h0, IMemReq},     64'h0);

        // Decode stalls five cycles; stray ack/update must not disturb anything.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h1234_5678, 1'b0, 1'b1, 64'h100);
            cmp("stall_InstrValid",  {63'h0, InstrValid},   64'h1);
            cmp("stall_Instruction", {32'h0, Instruction},  64'h8B02_0020);
            cmp("stall_CurrentPC",   CurrentPC,             64'h0);
            cmp("stall_Retired",     {32'h0, RetiredCount}, 64'h0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        cmp("exec_InstrValid", {63'h0, InstrValid}, 64'h0);

        step(1'b0, 32'h0, 1'b0, 1'b1, 64'h4);
        cmp("upd_CurrentPC", CurrentPC,             64'h4);
        cmp("upd_Retired",   {32'h0, RetiredCount}, 64'h1);
        cmp("upd_IMemReq",   {63'h0, IMemReq},      64'h1);
        cmp("upd_IMemAddr",  IMemAddr,              64'h4);

        // PCUpdate during FETCH and HOLD is not a retirement.
        step(1'b0, 32'h0, 1'b0, 1'b1, 64'h40);
        cmp("fetch_upd_Retired", {32'h0, RetiredCount}, 64'h1);
        step(1'b1, 32'hCAFE_0001, 1'b0, 1'b1, 64'h40);
        step(1'b0, 32'h0, 1'b0, 1'b1, 64'h40);
        cmp("hold_upd_Retired",  {32'h0, RetiredCount}, 64'h1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);

        // Counter wrap: deposit all-ones just before the retiring edge.
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        m_cnt = 32'hFFFF_FFFF;
        step(1'b0, 32'h0, 1'b0, 1'b1, 64'h8);
        cmp("wrap_Retired",   {32'h0, RetiredCount}, 64'h0);
        cmp("wrap_CurrentPC", CurrentPC,             64'h8);

        // Misaligned target leads to a frozen FAULT state.
        step(1'b1, 32'hAAAA_5555, 1'b0, 1'b0, 64'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 64'h6);
        cmp("fault_flag",      {63'h0, MisalignFault}, 64'h1);
        cmp("fault_CurrentPC", CurrentPC,              64'h6);
        cmp("fault_Retired",   {32'h0, RetiredCount},  64'h1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h0BAD_0BAD, 1'b1, 1'b1, 64'h100);
            cmp("frozen_CurrentPC",   CurrentPC,              64'h6);
            cmp("frozen_Instruction", {32'h0, Instruction},   64'hAAAA_5555);
            cmp("frozen_IMemReq",     {63'h0, IMemReq},       64'h0);
            cmp("frozen_InstrValid",  {63'h0, InstrValid},    64'h0);
            cmp("frozen_flag",        {63'h0, MisalignFault}, 64'h1);
        end
        async_reset();
        cmp("cleared_flag", {63'h0, MisalignFault}, 64'h0);

        // Reset in the middle of a fetch at a nonzero PC, then a late ack.
        step(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        step(1'b1, 32'h1111_2222, 1'b0, 1'b0, 64'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 64'h40);
        cmp("prefetch_IMemAddr", IMemAddr, 64'h40);
        async_reset();
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);
        cmp("late_ack_Instruction", {32'h0, Instruction}, 64'h0);
        cmp("late_ack_IMemReq",     {63'h0, IMemReq},     64'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ((m_phase == P_FAULT && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) != 0, rand_pc());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
